// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access in flight, word-aligned bus request, load align/extend.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of ignoring low address bits.
//
// state | meaning
// IDLE  | ready for a new access
// REQ   | bus request held, waiting for ack or timeout
// RESP  | one-cycle response strobe
module lsu_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    // Down-counter loaded at accept so the terminal count lands on the MAX_WAIT-th REQ cycle.
    localparam logic [TW-1:0] TLOAD = (MAX_WAIT == 0) ? '0 : TW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;

    logic          illegal;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c;
    logic [31:0]   lane;
    logic [31:0]   load_data;

    always_comb begin
        illegal = 1'b0;
        be_c    = 4'b0000;
        wdata_c = '0;
        case (req_funct3_i)
            3'd0, 3'd4: begin
                be_c    = 4'b0001 << req_addr_i[1:0];
                wdata_c = {4{req_wdata_i[7:0]}};
            end
            3'd1, 3'd5: begin
                be_c    = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_c = {2{req_wdata_i[15:0]}};
            end
            3'd2: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata_i;
            end
            default: illegal = 1'b1;
        endcase
        if (req_we_i && req_funct3_i[2])
            illegal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3_i == 3'd1 || req_funct3_i == 3'd5) && req_addr_i[0])
            illegal = 1'b1;
        if (req_funct3_i == 3'd2 && req_addr_i[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    always_comb begin
        lane = mem_rdata_i;
        case (funct3_q)
            3'd0, 3'd4: lane = mem_rdata_i >> {off_q, 3'b000};
            3'd1, 3'd5: lane = mem_rdata_i >> {off_q[1], 4'b0000};
            default:    lane = mem_rdata_i;
        endcase
        case (funct3_q)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd4:    load_data = {24'h0, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd5:    load_data = {16'h0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            timer       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        funct3_q    <= req_funct3_i;
                        off_q       <= req_addr_i[1:0];
                        if (illegal) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state       <= REQ;
                            timer       <= TLOAD;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                            mem_be_o    <= be_c;
                            mem_wdata_o <= req_we_i ? wdata_c : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i || (MAX_WAIT != 0 && timer == '0)) begin
                        // Ack takes priority over a timeout in the same cycle.
                        state       <= RESP;
                        timer       <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= mem_ack_i ? mem_err_i : 1'b1;
                        rsp_rdata_o <= (mem_ack_i && !mem_err_i && !mem_we_o) ? load_data : '0;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_be_o    <= '0;
                        mem_wdata_o <= '0;
                    end else if (MAX_WAIT != 0) begin
                        timer <= timer - 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, reset corner cases, random accesses vs. a lane-level model.
module tb_lsu_ctrl;

    localparam int TB_MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .mem_err_i    (mem_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] rdata;
        logic        berr;
        logic        x_ill;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_err;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ack_dly, input logic [31:0] rdata,
                                input logic berr, input logic x_ill, input logic [3:0] x_be,
                                input logic [31:0] x_wdata, input logic [31:0] x_rdata,
                                input logic x_err, input string tag);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.ack_dly = ack_dly;
        v.rdata = rdata; v.berr = berr; v.x_ill = x_ill; v.x_be = x_be;
        v.x_wdata = x_wdata; v.x_rdata = x_rdata; v.x_err = x_err; v.tag = tag;
        return v;
    endfunction

    // Reference model: accesses described as a run of byte lanes [start, start+size).
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int acc_start(input logic [2:0] f3, input logic [31:0] addr);
        int sz = acc_size(f3);
        if (sz == 4) return 0;
        if (sz == 2) return 2 * int'(addr[1]);
        return int'(addr[1:0]);
    endfunction

    function automatic logic model_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ill = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) ill = 1'b1;
`endif
        return ill;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be = '0;
        int st = acc_start(f3, addr);
        int sz = acc_size(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= st) && (i < st + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] w = '0;
        int sz = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int st = acc_start(f3, addr);
        int sz = acc_size(f3);
        longint unsigned val  = longint'(rdata) >> (8 * st);
        longint unsigned span = 64'd1 << (8 * sz);
        val = val % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && val >= span / 2) val = val + (64'h1_0000_0000 - span);
        return val[31:0];
    endfunction

    task automatic run_access(input vec_t v);
        logic acked = 1'b0;
        logic stray = 1'b0;
        chk({v.tag, "/ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (v.x_ill) begin
            chk({v.tag, "/ill_valid"}, rsp_valid, 1'b1);
            chk({v.tag, "/ill_err"}, rsp_err, 1'b1);
            chk({v.tag, "/ill_rdata"}, rsp_rdata, 32'h0);
            chk({v.tag, "/ill_memreq"}, mem_req, 1'b0);
            chk({v.tag, "/ill_ready"}, req_ready, 1'b0);
        end else begin
            for (int c = 0; c < TB_MAX_WAIT; c++) begin
                chk({v.tag, "/mem_req"}, mem_req, 1'b1);
                chk({v.tag, "/mem_we"}, mem_we, v.we);
                chk({v.tag, "/mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                chk({v.tag, "/mem_be"}, mem_be, v.x_be);
                if (v.we) chk({v.tag, "/mem_wdata"}, mem_wdata, v.x_wdata);
                chk({v.tag, "/req_rspv"}, rsp_valid, 1'b0);
                chk({v.tag, "/req_ready"}, req_ready, 1'b0);
                if (c == v.ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata; mem_err = v.berr;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom; mem_err = $urandom;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (c == v.ack_dly) begin
                    acked = 1'b1;
                    break;
                end
            end
            chk({v.tag, "/rsp_valid"}, rsp_valid, 1'b1);
            chk({v.tag, "/rsp_err"}, rsp_err, v.x_err);
            chk({v.tag, "/rsp_rdata"}, rsp_rdata, v.x_rdata);
            chk({v.tag, "/rsp_memreq"}, mem_req, 1'b0);
            chk({v.tag, "/rsp_ready"}, req_ready, 1'b0);
            if (!acked) begin
                stray = 1'b1;
                mem_ack = 1'b1; mem_rdata = $urandom; mem_err = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk({v.tag, "/after_rspv"}, rsp_valid, 1'b0);
        chk({v.tag, "/after_ready"}, req_ready, 1'b1);
        chk({v.tag, "/after_memreq"}, mem_req, 1'b0);
        if (stray) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk({v.tag, "/stray_rspv"}, rsp_valid, 1'b0);
            chk({v.tag, "/stray_memreq"}, mem_req, 1'b0);
            chk({v.tag, "/stray_ready"}, req_ready, 1'b1);
        end
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;

        vecs.push_back(mk(0, 3'd0, 32'h1003, 32'h0, 0, 32'h80FF_0000, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, "lb"));
        vecs.push_back(mk(1, 3'd1, 32'h2002, 32'h0000_BEEF, 2, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, "sh"));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 3'd5, 32'h3001, 32'h0, 1, 32'h1234_8001, 0, 1, 4'b0000, 32'h0, 32'h0, 1, "lhu_mis"));
        vecs.push_back(mk(0, 3'd2, 32'h8003, 32'h0, 0, 32'hCAFE_F00D, 0, 1, 4'b0000, 32'h0, 32'h0, 1, "lw_mis"));
`else
        vecs.push_back(mk(0, 3'd5, 32'h3001, 32'h0, 1, 32'h1234_8001, 0, 0, 4'b0011, 32'h0, 32'h0000_8001, 0, "lhu_mis"));
        vecs.push_back(mk(0, 3'd2, 32'h8003, 32'h0, 0, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, "lw_mis"));
`endif
        vecs.push_back(mk(0, 3'd2, 32'h4000, 32'h0, 10, 32'h0, 0, 0, 4'b1111, 32'h0, 32'h0, 1, "lw_timeout"));
        vecs.push_back(mk(0, 3'd3, 32'h5000, 32'h0, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 1, "ld_f3_3"));
        vecs.push_back(mk(1, 3'd4, 32'h5004, 32'h55, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 1, "sbu"));
        vecs.push_back(mk(0, 3'd2, 32'h0010, 32'h0, 3, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, "lw_ack_at_to"));
        vecs.push_back(mk(0, 3'd1, 32'h4002, 32'h0, 0, 32'h8001_7FFF, 0, 0, 4'b1100, 32'h0, 32'hFFFF_8001, 0, "lh"));
        vecs.push_back(mk(0, 3'd4, 32'h5001, 32'h0, 1, 32'h0000_AB00, 0, 0, 4'b0010, 32'h0, 32'h0000_00AB, 0, "lbu"));
        vecs.push_back(mk(0, 3'd2, 32'h6004, 32'h0, 0, 32'hFFFF_FFFF, 1, 0, 4'b1111, 32'h0, 32'h0, 1, "lw_buserr"));
        vecs.push_back(mk(1, 3'd2, 32'h7000, 32'h1122_3344, 1, 32'h0, 0, 0, 4'b1111, 32'h1122_3344, 32'h0, 0, "sw"));
        vecs.push_back(mk(1, 3'd0, 32'h7001, 32'h0000_00A5, 0, 32'h0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0, "sb"));
        vecs.push_back(mk(1, 3'd7, 32'h7008, 32'h0, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 1, "st_f3_7"));

        repeat (2) @(posedge clk);
        #1;
        chk("reset/ready", req_ready, 1'b1);
        chk("reset/rspv", rsp_valid, 1'b0);
        chk("reset/rsperr", rsp_err, 1'b0);
        chk("reset/rdata", rsp_rdata, 32'h0);
        chk("reset/memreq", mem_req, 1'b0);
        chk("reset/memaddr", mem_addr, 32'h0);
        chk("reset/membe", mem_be, 4'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_access(vecs[i]);

        // Reset asserted while the bus request is outstanding.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid/memreq_before", mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid/memreq_now", mem_req, 1'b0);
        chk("rstmid/rspv_now", rsp_valid, 1'b0);
        chk("rstmid/ready_now", req_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rstmid/rspv_after", rsp_valid, 1'b0);
            chk("rstmid/ready_after", req_ready, 1'b1);
            chk("rstmid/memreq_after", mem_req, 1'b0);
        end
        mem_ack = 1'b0;

        for (int n = 0; n < 150; n++) begin
            rv.we      = $urandom;
            rv.f3      = 3'($urandom);
            rv.addr    = $urandom;
            rv.wdata   = $urandom;
            rv.ack_dly = $urandom_range(0, 5);
            rv.rdata   = $urandom;
            rv.berr    = ($urandom_range(0, 7) == 0);
            rv.tag     = "rand";
            rv.x_ill   = model_illegal(rv.we, rv.f3, rv.addr);
            rv.x_be    = model_be(rv.f3, rv.addr);
            rv.x_wdata = model_wdata(rv.f3, rv.wdata);
            if (rv.x_ill) begin
                rv.x_err = 1'b1; rv.x_rdata = '0;
            end else if (rv.ack_dly >= TB_MAX_WAIT) begin
                rv.x_err = 1'b1; rv.x_rdata = '0;
            end else begin
                rv.x_err   = rv.berr;
                rv.x_rdata = (rv.we || rv.berr) ? 32'h0 : model_load(rv.f3, rv.addr, rv.rdata);
            end
            run_access(rv);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("rand/idle_rspv", rsp_valid, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
